sub_bytes_pipe: RTL and testbench



---
 rtl/sub_bytes_pipe.sv | 188 ++++++++++++++++++
 tb/tb_sub_bytes_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: multi-cycle AES SubBytes engine.
// A NUM_BYTES-byte state word is captured on the input handshake and substituted
// in place, LANES bytes per clock, over BEATS = NUM_BYTES/LANES clocks. The result
// is presented on out_data with out_valid until the consumer takes it.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block can accept a word (IDLE only)
//   in_data    state word, byte i = in_data[8*i+7:8*i]
//   in_inv     1 = inverse S-box, sampled at accept
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out_data   substituted word, same byte order (zero outside DONE)
//   busy       high in BUSY or DONE
//
// Build option: define SUB_BYTES_INV_EN to build the inverse S-box and honour
// in_inv. Without it, in_inv is ignored and the forward S-box is always used.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a word, in_ready=1
// BUSY  | substituting slice cnt of the working register each clock
// DONE  | result held on out_data with out_valid=1 until out_ready

module sub_bytes_pipe #(
   parameter int NUM_BYTES = 16,
   parameter int LANES     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*NUM_BYTES-1:0] in_data,
   input  logic                   in_inv,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*NUM_BYTES-1:0] out_data,
   output logic                   busy
);

   localparam int W     = 8 * NUM_BYTES;
   localparam int BEATS = (LANES >= 1) ? NUM_BYTES / LANES : 1;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   generate
      if (LANES < 1) begin : g_bad_lanes
         $error("sub_bytes_pipe: LANES must be >= 1");
      end else if ((NUM_BYTES % LANES) != 0) begin : g_bad_div
         $error("sub_bytes_pipe: LANES must divide NUM_BYTES");
      end
   endgenerate

   // Tables are packed with entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return SBOX_FWD[2040 - 8 * int'(b) +: 8];
   endfunction

`ifdef SUB_BYTES_INV_EN
   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return SBOX_INV[2040 - 8 * int'(b) +: 8];
   endfunction

   logic mode, mode_nxt;
`else
   logic unused_inv;
   assign unused_inv = in_inv;
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [W-1:0]    work, work_nxt;
   int              base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         work  <= '0;
`ifdef SUB_BYTES_INV_EN
         mode  <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         work  <= work_nxt;
`ifdef SUB_BYTES_INV_EN
         mode  <= mode_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      work_nxt  = work;
`ifdef SUB_BYTES_INV_EN
      mode_nxt  = mode;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_data  = '0;
      // With a single beat the whole word is one slice and cnt stays 0.
      base      = (BEATS > 1) ? int'(cnt) * LANES : 0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_nxt  = in_data;
`ifdef SUB_BYTES_INV_EN
               mode_nxt  = in_inv;
`endif
               cnt_nxt   = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            for (int l = 0; l < LANES; l++) begin
`ifdef SUB_BYTES_INV_EN
               work_nxt[8*(base+l) +: 8] = mode ? sbox_inv(work[8*(base+l) +: 8])
                                                : sbox_fwd(work[8*(base+l) +: 8]);
`else
               work_nxt[8*(base+l) +: 8] = sbox_fwd(work[8*(base+l) +: 8]);
`endif
            end
            if (cnt == LAST) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = work;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb_sub_bytes_pipe: directed-vector bench for sub_bytes_pipe. A default
// instance (LANES=4) carries the handshake, backpressure and reset tests;
// three extra instances (LANES=1/2/16) check latency and data for the sweep.

module tb_sub_bytes_pipe;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_inv = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_data;

   always #5 clk = ~clk;

   sub_bytes_pipe #(.NUM_BYTES(16), .LANES(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   logic         sv = 1'b0;
   logic [127:0] sd = '0;
   logic [2:0]   s_ready, s_valid, s_busy;
   logic [127:0] s_data [3];

   sub_bytes_pipe #(.NUM_BYTES(16), .LANES(1)) u_l1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(sv), .in_ready(s_ready[0]), .in_data(sd), .in_inv(1'b0),
      .out_valid(s_valid[0]), .out_ready(1'b1), .out_data(s_data[0]), .busy(s_busy[0])
   );
   sub_bytes_pipe #(.NUM_BYTES(16), .LANES(2)) u_l2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(sv), .in_ready(s_ready[1]), .in_data(sd), .in_inv(1'b0),
      .out_valid(s_valid[1]), .out_ready(1'b1), .out_data(s_data[1]), .busy(s_busy[1])
   );
   sub_bytes_pipe #(.NUM_BYTES(16), .LANES(16)) u_l16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(sv), .in_ready(s_ready[2]), .in_data(sd), .in_inv(1'b0),
      .out_valid(s_valid[2]), .out_ready(1'b1), .out_data(s_data[2]), .busy(s_busy[2])
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] fill(input logic [7:0] b);
      return {16{b}};
   endfunction

   // Present a word, wait (bounded) for in_ready, accept on the next edge,
   // then scramble the inputs to show they no longer matter.
   task automatic send(input string tag, input logic [127:0] d, input logic inv);
      int n;
      n = 0;
      in_data  = d;
      in_inv   = inv;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, 128'(in_ready), 128'(1));
      tick();
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_inv   = ~inv;
   endtask

   // Count edges after the accepting edge until out_valid is seen.
   task automatic wait_out(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
   endtask

   initial begin
      logic [7:0]   pat [3];
      logic [7:0]   res [3];
      logic [127:0] w_in, w_exp, a_exp;
      int           first [3];
      logic [127:0] got [3];
      int           seen;

      // reset state
      #12;
      chk("rst_in_ready",  128'(in_ready),  128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy",      128'(busy),      128'(0));
      chk("rst_out_data",  out_data,        128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: all zero -> all 0x63, back to IDLE one cycle after valid
      out_ready = 1'b1;
      send("t1", '0, 1'b0);
      chk("t1_busy", 128'(busy), 128'(1));
      wait_out("t1", 4);
      chk("t1_data", out_data, fill(8'h63));
      tick();
      chk("t1_idle_ready", 128'(in_ready),  128'(1));
      chk("t1_idle_valid", 128'(out_valid), 128'(0));
      chk("t1_idle_busy",  128'(busy),      128'(0));

      // 2: byte i = i
      send("t2", 128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
      wait_out("t2", 4);
      chk("t2_data", out_data, 128'h76abd7fe2b670130c56f6bf27b777c63);
      tick();

      // 3: 0x63, 0xed, 0x16 repeating with in_inv=1
      pat[0] = 8'h63; pat[1] = 8'hed; pat[2] = 8'h16;
`ifdef SUB_BYTES_INV_EN
      res[0] = 8'h00; res[1] = 8'h53; res[2] = 8'hff;
`else
      res[0] = 8'hfb; res[1] = 8'h55; res[2] = 8'h47;
`endif
      for (int i = 0; i < 16; i++) begin
         w_in[8*i +: 8]  = pat[i % 3];
         w_exp[8*i +: 8] = res[i % 3];
      end
      send("t3", w_in, 1'b1);
      wait_out("t3", 4);
      chk("t3_data", out_data, w_exp);
      tick();

      // 4: backpressure in DONE with a second word pending
      out_ready = 1'b0;
      a_exp = 128'hc072a49cafa2d4adf04759fa7dc982ca;
      send("t4a", 128'h1f1e1d1c1b1a19181716151413121110, 1'b0);
      wait_out("t4a", 4);
      in_data  = fill(8'hff);
      in_inv   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("t4_hold_data",  out_data,          a_exp);
         chk("t4_hold_ready", 128'(in_ready),  128'(0));
         chk("t4_hold_valid", 128'(out_valid), 128'(1));
         tick();
      end
      out_ready = 1'b1;
      chk("t4_hs_ready", 128'(in_ready), 128'(0));
      tick();
      chk("t4_post_ready", 128'(in_ready),  128'(1));
      chk("t4_post_valid", 128'(out_valid), 128'(0));
      chk("t4_post_busy",  128'(busy),      128'(0));
      tick();
      chk("t4b_accepted", 128'(busy), 128'(1));
      in_valid = 1'b0;
      in_data  = '0;
      wait_out("t4b", 4);
      chk("t4b_data", out_data, fill(8'h16));
      tick();

      // 5: reset mid-BUSY at cnt=2
      send("t5a", fill(8'h99), 1'b0);
      tick();
      tick();
      chk("t5_pre_busy", 128'(busy), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", 128'(in_ready),  128'(1));
      chk("t5_rst_valid", 128'(out_valid), 128'(0));
      chk("t5_rst_busy",  128'(busy),      128'(0));
      chk("t5_rst_data",  out_data,        128'(0));
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid || busy) seen = 1;
         tick();
      end
      chk("t5_no_output", 128'(seen), 128'(0));
      send("t5b", fill(8'h53), 1'b0);
      wait_out("t5b", 4);
      chk("t5b_data", out_data, fill(8'hed));
      tick();

      // 6: LANES sweep, 0x53 everywhere -> 0xed, latency 16/8/1
      sd = fill(8'h53);
      sv = 1'b1;
      chk("t6_ready", 128'(s_ready), 128'(3'b111));
      tick();
      sv = 1'b0;
      for (int k = 0; k < 3; k++) begin
         first[k] = -1;
         got[k]   = '0;
      end
      for (int lat = 1; lat <= 30; lat++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            if (s_valid[k] && first[k] < 0) begin
               first[k] = lat;
               got[k]   = s_data[k];
            end
         end
      end
      chk("t6_l1_lat",   128'(first[0]), 128'(16));
      chk("t6_l2_lat",   128'(first[1]), 128'(8));
      chk("t6_l16_lat",  128'(first[2]), 128'(1));
      chk("t6_l1_data",  got[0], fill(8'hed));
      chk("t6_l2_data",  got[1], fill(8'hed));
      chk("t6_l16_data", got[2], fill(8'hed));
      chk("t6_idle", 128'(s_busy), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
